// File: rtl/ts_chan_mux.sv
// rtl/ts_chan_mux.sv - round-robin merge of per-channel TS packet FIFOs into one framed stream
module ts_chan_mux #(
    parameter int N_CHAN     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PKT_WORDS  = 48,
    parameter int TIMEOUT    = 255
) (
    input  logic                         payload_clk,
    input  logic                         payload_rst,
    input  logic [N_CHAN-1:0]            chan_pend,
    output logic [N_CHAN-1:0]            chan_out_req,
    input  logic [N_CHAN-1:0]            chan_out_ack,
    input  logic [N_CHAN-1:0]            chan_valid,
    input  logic [N_CHAN-1:0]            chan_start,
    input  logic [N_CHAN-1:0]            chan_end,
    input  logic [N_CHAN*DATA_WIDTH-1:0] chan_data,
    input  logic                         out_ready,
    output logic                         mux_valid,
    output logic                         mux_start,
    output logic                         mux_end,
    output logic [DATA_WIDTH-1:0]        mux_data,
    output logic [$clog2(N_CHAN)-1:0]    mux_chan,
    output logic                         pkt_len_err,
    output logic                         timeout_err
);

    localparam int                CW       = $clog2(N_CHAN);
    localparam logic [7:0]        PKT_LEN  = 8'(PKT_WORDS);
    localparam logic [7:0]        TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [CW-1:0]     LAST_RST = CW'(N_CHAN - 1);
    localparam logic [N_CHAN-1:0] REQ_ONE  = {{(N_CHAN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_GAP} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           last_grant;
    logic [CW-1:0]           rr_grant, rr_idx;
    logic                    rr_found;
    logic [7:0]              count_q, cnt_next;
    logic [7:0]              timer_q;
    logic                    g_valid, g_start, g_end, g_ack, g_last;
    logic [DATA_WIDTH-1:0]   g_data;
    logic                    do_grant, do_fwd, do_end, do_timeout, len_err;

    // Round-robin pick: scan from farthest to nearest so the channel right after last_grant wins
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        rr_idx   = '0;
        for (int k = N_CHAN; k >= 1; k--) begin
            rr_idx = CW'((int'(last_grant) + k) % N_CHAN);
            if (chan_pend[rr_idx]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx;
            end
        end
    end

    // Select the granted channel's strobes and data; everything else is ignored
    always_comb begin
        g_valid = 1'b0;
        g_start = 1'b0;
        g_end   = 1'b0;
        g_ack   = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            if (mux_chan == CW'(i)) begin
                g_valid = chan_valid[i];
                g_start = chan_start[i];
                g_end   = chan_end[i];
                g_ack   = chan_out_ack[i];
                g_data  = chan_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        // ack is advisory: an end word completes the packet with or without it
        g_last = g_end | (g_end & g_ack);
    end

    // State register
    always_ff @(posedge payload_clk or posedge payload_rst) begin
        if (payload_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle strobes for the datapath
    always_comb begin
        state_d    = state_q;
        do_grant   = 1'b0;
        do_fwd     = 1'b0;
        do_end     = 1'b0;
        do_timeout = 1'b0;
        len_err    = 1'b0;
        cnt_next   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (out_ready && rr_found) begin
                    do_grant = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (g_valid && g_start) begin
                    do_fwd   = 1'b1;
                    cnt_next = 8'd1;
                    state_d  = ST_XFER;
                    if (g_last) begin
                        do_end  = 1'b1;
                        len_err = (cnt_next != PKT_LEN);
                        state_d = ST_GAP;
                    end
                end else if (timer_q == TO_LAST) begin
                    do_timeout = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            ST_XFER: begin
                if (g_valid) begin
                    do_fwd = 1'b1;
                    if (g_start) begin
                        // restart framing on a premature start; the lost packet is flagged
                        cnt_next = 8'd1;
                        len_err  = 1'b1;
                    end else begin
                        cnt_next = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    end
                    if (g_last) begin
                        do_end  = 1'b1;
                        state_d = ST_GAP;
                        if (cnt_next != PKT_LEN) begin
                            len_err = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, grant bookkeeping, word counter and start timer
    always_ff @(posedge payload_clk or posedge payload_rst) begin
        if (payload_rst) begin
            chan_out_req <= '0;
            last_grant   <= LAST_RST;
            mux_chan     <= '0;
            mux_valid    <= 1'b0;
            mux_start    <= 1'b0;
            mux_end      <= 1'b0;
            mux_data     <= '0;
            pkt_len_err  <= 1'b0;
            timeout_err  <= 1'b0;
            count_q      <= '0;
            timer_q      <= '0;
        end else begin
            mux_valid   <= do_fwd;
            mux_start   <= do_fwd & g_start;
            mux_end     <= do_end;
            mux_data    <= do_fwd ? g_data : '0;
            pkt_len_err <= len_err;
            timeout_err <= do_timeout;
            count_q     <= cnt_next;
            timer_q     <= (state_q == ST_REQ) ? timer_q + 8'd1 : timer_q;
            if (do_grant) begin
                chan_out_req <= REQ_ONE << rr_grant;
                mux_chan     <= rr_grant;
                count_q      <= '0;
                timer_q      <= '0;
            end
            if (do_end || do_timeout) begin
                chan_out_req <= '0;
                last_grant   <= mux_chan;
            end
        end
    end

endmodule

// File: tb/tb_ts_chan_mux.sv
// tb/tb_ts_chan_mux.sv - directed self-checking bench for ts_chan_mux
module tb_ts_chan_mux;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            payload_clk;
    logic            payload_rst;
    logic [N-1:0]    chan_pend;
    logic [N-1:0]    chan_out_req;
    logic [N-1:0]    chan_out_ack;
    logic [N-1:0]    chan_valid;
    logic [N-1:0]    chan_start;
    logic [N-1:0]    chan_end;
    logic [N*DW-1:0] chan_data;
    logic            out_ready;
    logic            mux_valid;
    logic            mux_start;
    logic            mux_end;
    logic [DW-1:0]   mux_data;
    logic [1:0]      mux_chan;
    logic            pkt_len_err;
    logic            timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    int cyc      = 0;
    int last_end = 0;
    int have_end = 0;
    int min_gap  = 100000;
    int n_end    = 0;
    int n_len    = 0;
    int n_to     = 0;

    ts_chan_mux #(.N_CHAN(N), .DATA_WIDTH(DW), .PKT_WORDS(48), .TIMEOUT(255)) dut (
        .payload_clk  (payload_clk),
        .payload_rst  (payload_rst),
        .chan_pend    (chan_pend),
        .chan_out_req (chan_out_req),
        .chan_out_ack (chan_out_ack),
        .chan_valid   (chan_valid),
        .chan_start   (chan_start),
        .chan_end     (chan_end),
        .chan_data    (chan_data),
        .out_ready    (out_ready),
        .mux_valid    (mux_valid),
        .mux_start    (mux_start),
        .mux_end      (mux_end),
        .mux_data     (mux_data),
        .mux_chan     (mux_chan),
        .pkt_len_err  (pkt_len_err),
        .timeout_err  (timeout_err)
    );

    always #5 payload_clk = ~payload_clk;

    // Output event monitor: packet spacing and error pulse counts
    always @(negedge payload_clk) begin
        cyc = cyc + 1;
        if (mux_valid && mux_start && have_end != 0) begin
            if (cyc - last_end < min_gap) min_gap = cyc - last_end;
        end
        if (mux_end) begin
            last_end = cyc;
            have_end = 1;
            n_end    = n_end + 1;
        end
        if (pkt_len_err) n_len = n_len + 1;
        if (timeout_err) n_to = n_to + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {19'b0, chan_out_req, mux_valid, mux_start, mux_end, mux_data, mux_chan,
                pkt_len_err, timeout_err};
    endfunction

    task automatic do_reset();
        payload_rst  = 1'b1;
        chan_pend    = '0;
        chan_valid   = '0;
        chan_start   = '0;
        chan_end     = '0;
        chan_out_ack = '0;
        chan_data    = '0;
        repeat (3) @(negedge payload_clk);
        payload_rst = 1'b0;
        @(negedge payload_clk);
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        while (chan_out_req == '0 && k < 600) begin
            @(negedge payload_clk);
            k++;
        end
    endtask

    // FIFO model: wait for the grant, then stream n words and check each output word
    task automatic send_pkt(input int ch, input int n, input int id, input bit exp_err,
                            input bit last);
        logic [63:0] obs, exp;
        logic [DW-1:0] d;
        wait_req();
        chk($sformatf("grant_ch%0d_id%0d", ch, id), 64'(chan_out_req), 64'(1) << ch);
        for (int w = 0; w < n; w++) begin
            d = {8'(ch), 8'(id), 16'(w)};
            chan_valid[ch]        = 1'b1;
            chan_start[ch]        = (w == 0);
            chan_end[ch]          = (w == n - 1);
            chan_out_ack[ch]      = (w == n - 1);
            chan_data[ch*DW +: DW] = d;
            if (w == n - 1 && last) chan_pend[ch] = 1'b0;
            @(negedge payload_clk);
            obs = {24'b0, mux_valid, mux_start, mux_end, pkt_len_err, 2'b0, mux_chan, mux_data};
            exp = {24'b0, 1'b1, (w == 0), (w == n - 1), (exp_err && w == n - 1), 4'(ch), d};
            chk($sformatf("word_ch%0d_id%0d_w%0d", ch, id, w), obs, exp);
        end
        chan_valid[ch]         = 1'b0;
        chan_start[ch]         = 1'b0;
        chan_end[ch]           = 1'b0;
        chan_out_ack[ch]       = 1'b0;
        chan_data[ch*DW +: DW] = '0;
        chk($sformatf("req_drop_ch%0d_id%0d", ch, id), 64'(chan_out_req), 64'd0);
    endtask

    initial begin
        int k, snap_len, snap_end;
        bit bad;
        payload_clk  = 1'b0;
        payload_rst  = 1'b1;
        out_ready    = 1'b1;
        chan_pend    = '0;
        chan_valid   = '0;
        chan_start   = '0;
        chan_end     = '0;
        chan_out_ack = '0;
        chan_data    = '0;
        repeat (2) @(negedge payload_clk);
        chk("reset_outputs", all_outs(), 64'd0);
        payload_rst = 1'b0;
        @(negedge payload_clk);

        // 1: single channel, nominal packet
        chan_pend[1] = 1'b1;
        @(negedge payload_clk);
        chk("t1_req_latency", 64'(chan_out_req), 64'b0010);
        send_pkt(1, 48, 1, 1'b0, 1'b1);
        repeat (2) @(negedge payload_clk);
        chk("t1_no_len_err", 64'(n_len), 64'd0);
        chk("t1_no_timeout", 64'(n_to), 64'd0);

        // 2: two channels alternate, minimum spacing
        do_reset();
        chan_pend = 4'b0101;
        send_pkt(0, 48, 10, 1'b0, 1'b0);
        send_pkt(2, 48, 11, 1'b0, 1'b0);
        send_pkt(0, 48, 12, 1'b0, 1'b1);
        send_pkt(2, 48, 13, 1'b0, 1'b1);
        chk("t2_min_gap", 64'(min_gap), 64'd3);

        // 3: granted channel never starts
        chan_pend = 4'b1001;
        wait_req();
        chk("t3_grant_ch3", 64'(chan_out_req), 64'b1000);
        k = 0;
        do begin
            @(negedge payload_clk);
            k++;
        end while (!timeout_err && k < 300);
        chk("t3_timeout_delay", 64'(k), 64'd255);
        chk("t3_req_dropped", 64'(chan_out_req), 64'd0);
        chan_pend[3] = 1'b0;
        chan_valid[1] = 1'b1;
        chan_start[1] = 1'b1;
        chan_end[1]   = 1'b1;
        chan_data[1*DW +: DW] = 32'hDEADBEEF;
        send_pkt(0, 48, 20, 1'b0, 1'b1);
        chan_valid[1] = 1'b0;
        chan_start[1] = 1'b0;
        chan_end[1]   = 1'b0;
        chan_data[1*DW +: DW] = '0;
        repeat (2) @(negedge payload_clk);
        chk("t3_timeout_count", 64'(n_to), 64'd1);

        // 4: short then long packet
        snap_len = n_len;
        chan_pend[1] = 1'b1;
        send_pkt(1, 47, 30, 1'b1, 1'b0);
        send_pkt(1, 49, 31, 1'b1, 1'b1);
        repeat (2) @(negedge payload_clk);
        chk("t4_len_err_count", 64'(n_len - snap_len), 64'd2);

        // 5: out_ready holds off grants
        do_reset();
        out_ready = 1'b0;
        chan_pend = 4'b1111;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge payload_clk);
            if (chan_out_req != '0) bad = 1'b1;
        end
        chk("t5_no_req_when_not_ready", 64'(bad), 64'd0);
        out_ready = 1'b1;
        send_pkt(0, 48, 40, 1'b0, 1'b1);
        chan_pend = '0;
        repeat (3) @(negedge payload_clk);

        // 6: reset in the middle of a packet
        chan_pend[2] = 1'b1;
        wait_req();
        chk("t6_grant_ch2", 64'(chan_out_req), 64'b0100);
        for (int w = 0; w < 20; w++) begin
            chan_valid[2] = 1'b1;
            chan_start[2] = (w == 0);
            chan_data[2*DW +: DW] = {8'd2, 8'd50, 16'(w)};
            @(negedge payload_clk);
        end
        snap_end = n_end;
        chan_data[2*DW +: DW] = {8'd2, 8'd50, 16'd20};
        payload_rst = 1'b1;
        @(negedge payload_clk);
        chk("t6_outputs_in_reset", all_outs(), 64'd0);
        chan_valid = '0;
        chan_start = '0;
        chan_data  = '0;
        chan_pend  = 4'b0101;
        repeat (2) @(negedge payload_clk);
        payload_rst = 1'b0;
        wait_req();
        chan_pend[2] = 1'b0;
        send_pkt(0, 48, 51, 1'b0, 1'b1);
        repeat (2) @(negedge payload_clk);
        chk("t6_aborted_never_ended", 64'(n_end - snap_end), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
